// File: rtl/cf_record_packer.sv
// Control-flow record packer: classifies retiring MIPS instructions, builds
// {meta, instr} records and queues them in a first-word-fall-through FIFO.
module cf_record_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_next_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_rec,
    output logic             full,
    output logic [CNT_W-1:0] cf_cnt,
    output logic             zero_tgt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] cf_cnt_q, cf_cnt_d;
    logic             zero_tgt_q, zero_tgt_d;

    logic [5:0]       op, funct;
    logic [4:0]       rt;
    logic             is_cf;
    logic [63:0]      rec;
    logic             acc, pop;

    // Decode control-flow opcodes and build the record for the current instruction.
    always_comb begin
        op    = in_instr[31:26];
        rt    = in_instr[20:16];
        funct = in_instr[5:0];
        is_cf = 1'b0;
        if (op >= 6'd2 && op <= 6'd7) begin
            is_cf = 1'b1;
        end else if (op == 6'd0 && (funct == 6'd8 || funct == 6'd9)) begin
            is_cf = 1'b1;
        end else if (op == 6'd1 &&
                     (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17)) begin
            is_cf = 1'b1;
        end
        rec = {is_cf ? in_next_pc : 32'h0, in_instr};
    end

    assign full      = (count_q == FULL_CNT);
    assign in_ready  = ~full;
    assign out_valid = (count_q != '0);
    assign out_rec   = out_valid ? mem_q[rd_ptr_q] : 64'h0;
    assign cf_cnt    = cf_cnt_q;
    assign zero_tgt_err = zero_tgt_q;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // Next-state for pointers, occupancy, counter and sticky error flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cf_cnt_d   = cf_cnt_q;
        zero_tgt_d = zero_tgt_q;
        if (acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (acc && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !acc) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (acc && is_cf) begin
            if (cf_cnt_q != '1) begin
                cf_cnt_d = cf_cnt_q + CNT_W'(1);
            end
            if (in_next_pc == 32'h0) begin
                zero_tgt_d = 1'b1;
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cf_cnt_q   <= '0;
            zero_tgt_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cf_cnt_q   <= cf_cnt_d;
            zero_tgt_q <= zero_tgt_d;
        end
    end

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && acc) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

endmodule

// File: tb/tb_cf_record_packer.sv
// Directed testbench for cf_record_packer with hand-computed expected records.
module tb_cf_record_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_next_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rec;
    logic        full;
    logic [31:0] cf_cnt;
    logic        zero_tgt_err;

    int n_run  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    cf_record_packer #(.DEPTH(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_next_pc   (in_next_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rec      (out_rec),
        .full         (full),
        .cf_cnt       (cf_cnt),
        .zero_tgt_err (zero_tgt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [63:0] exp);
        chk("push_ready", {63'h0, in_ready}, 64'h1);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_next_pc = pc;
        step();
        in_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", {63'h0, out_valid}, 64'h1);
            chk("drain_rec", out_rec, exp_q.pop_front());
            step();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 32'h11090003;
        in_next_pc = 32'h00400020;
        out_ready  = 1'b0;

        // 1: reset held two cycles with in_valid asserted
        step();
        step();
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_cf_cnt", {32'h0, cf_cnt}, 64'h0);
        chk("rst_full", {63'h0, full}, 64'h0);
        chk("rst_out_rec", out_rec, 64'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("post_rst_empty", {63'h0, out_valid}, 64'h0);

        // 2: non-control-flow instruction carries meta=0
        push(32'h012A4020, 32'h00400008, 64'h00000000_012A4020);
        chk("ncf_valid", {63'h0, out_valid}, 64'h1);
        chk("ncf_rec", out_rec, 64'h00000000_012A4020);
        chk("ncf_cf_cnt", {32'h0, cf_cnt}, 64'h0);
        drain(1);
        chk("ncf_empty", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("empty_pop_ignored", {63'h0, out_valid}, 64'h0);

        // 3: beq, jr, bgezal
        push(32'h11090003, 32'h00400020, 64'h00400020_11090003);
        push(32'h03E00008, 32'h00400100, 64'h00400100_03E00008);
        push(32'h04110002, 32'h00400040, 64'h00400040_04110002);
        chk("cf_cnt3", {32'h0, cf_cnt}, 64'd3);
        chk("cf_no_err", {63'h0, zero_tgt_err}, 64'h0);
        drain(3);

        // 4: fill, backpressure, pop one, fifth accepted
        push(32'h04020005, 32'h00001234, 64'h00000000_04020005);
        push(32'h0000F809, 32'h00400200, 64'h00400200_0000F809);
        push(32'h1C400001, 32'h00400300, 64'h00400300_1C400001);
        chk("not_full3", {63'h0, full}, 64'h0);
        push(32'h012A4020, 32'h00000000, 64'h00000000_012A4020);
        chk("full4", {63'h0, full}, 64'h1);
        chk("ready4", {63'h0, in_ready}, 64'h0);
        in_valid   = 1'b1;
        in_instr   = 32'h3C010040;
        in_next_pc = 32'h00400400;
        step();
        chk("held_full", {63'h0, full}, 64'h1);
        chk("held_ready", {63'h0, in_ready}, 64'h0);
        chk("held_head", out_rec, exp_q[0]);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("after_pop_ready", {63'h0, in_ready}, 64'h1);
        chk("after_pop_head", out_rec, 64'h00400200_0000F809);
        step();
        in_valid = 1'b0;
        exp_q.push_back(64'h00000000_3C010040);
        chk("fifth_full", {63'h0, full}, 64'h1);
        chk("cf_cnt5", {32'h0, cf_cnt}, 64'd5);
        chk("ncf_zero_pc_no_err", {63'h0, zero_tgt_err}, 64'h0);
        drain(4);
        chk("t4_empty", {63'h0, out_valid}, 64'h0);

        // 5: simultaneous push and pop at occupancy 2
        push(32'h00850820, 32'h00500000, 64'h00000000_00850820);
        push(32'h00850821, 32'h00500004, 64'h00000000_00850821);
        for (int i = 0; i < 10; i++) begin
            chk("pp_head", out_rec, exp_q[0]);
            chk("pp_not_full", {63'h0, full}, 64'h0);
            in_valid   = 1'b1;
            out_ready  = 1'b1;
            in_instr   = 32'h00850822 + 32'(i);
            in_next_pc = 32'h00500008 + 32'(4 * i);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back({32'h0, 32'h00850822 + 32'(i)});
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain(2);
        chk("pp_count2_empty", {63'h0, out_valid}, 64'h0);

        // 6: zero-target jump, then reset with entries queued
        push(32'h08000000, 32'h00000000, 64'h00000000_08000000);
        chk("zt_err_set", {63'h0, zero_tgt_err}, 64'h1);
        chk("cf_cnt6", {32'h0, cf_cnt}, 64'd6);
        chk("zt_rec", out_rec, 64'h00000000_08000000);
        push(32'h012A4020, 32'h00400008, 64'h00000000_012A4020);
        push(32'h11090003, 32'h00400020, 64'h00400020_11090003);
        chk("zt_err_sticky", {63'h0, zero_tgt_err}, 64'h1);
        chk("zt_head", out_rec, 64'h00000000_08000000);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_q.delete();
        chk("mrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("mrst_out_rec", out_rec, 64'h0);
        chk("mrst_full", {63'h0, full}, 64'h0);
        chk("mrst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("mrst_err", {63'h0, zero_tgt_err}, 64'h0);
        chk("mrst_cf_cnt", {32'h0, cf_cnt}, 64'h0);
        step();
        chk("mrst_still_empty", {63'h0, out_valid}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
